// File: rtl/rom_reader_pkg.sv
// Shared types and helpers for the multi-port ROM reader.
// Holds the channel FSM state type, the default error word and address decode.
package rom_reader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } rom_state_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    // Byte offset of addr from base; callers truncate to their bus width so
    // the subtraction wraps modulo 2**ADDR_WIDTH.
    function automatic logic [63:0] addr_to_index(
        input logic [63:0] addr,
        input logic [63:0] base
    );
        return addr - base;
    endfunction

endpackage

// File: rtl/rom_read_channel.sv
// One ROM read channel: address decode, latency counter and response FSM.
// Ports: clk_i/rst_i, req_i+addr_i request, rom_addr_o/rom_dout_i macro port,
// busy_o, rvalid_o, rerr_o, rdata_o response.
module rom_read_channel
    import rom_reader_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH       = 1024,
    parameter int                    IDX_W       = $clog2(DEPTH),
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(32'h1FC0_0000),
    parameter int                    ROM_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA    = DATA_WIDTH'(ERR_DATA_DEFAULT)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] rom_dout_i,
    output logic                  busy_o,
    output logic                  rvalid_o,
    output logic                  rerr_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [IDX_W-1:0]      rom_addr_o
);

    localparam int CNT_W = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;

    rom_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    logic [ADDR_WIDTH-1:0] off;
    logic [ADDR_WIDTH-1:0] word_off;
    logic                  bad;

    // Addresses below BASE_ADDR wrap to a huge offset and fail the range test.
    assign off      = ADDR_WIDTH'(addr_to_index(64'(addr_i), 64'(BASE_ADDR)));
    assign word_off = off >> 2;
    assign bad      = (off[1:0] != 2'b00) || (word_off >= ADDR_WIDTH'(DEPTH));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    if (bad) begin
                        err_d   = 1'b1;
                        rdata_d = ERR_DATA;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        idx_d   = word_off[IDX_W-1:0];
                        cnt_d   = CNT_W'(ROM_LATENCY - 1);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d = rom_dout_i;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            idx_q   <= idx_d;
        end
    end

    assign busy_o     = (state_q != IDLE);
    assign rvalid_o   = (state_q == RESP);
    assign rerr_o     = (state_q == RESP) && err_q;
    assign rdata_o    = rdata_q;
    assign rom_addr_o = idx_q;

endmodule

// File: rtl/rom_multiport_reader.sv
// Multi-port ROM front-end: NUM_PORTS independent read channels, one macro port each.
// Ports: clk/rst, per-channel req/addr in, busy/rvalid/rerr/rdata out, rom_addr/rom_dout macro.
module rom_multiport_reader
    import rom_reader_pkg::*;
#(
    parameter int                    NUM_PORTS   = 2,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH       = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(32'h1FC0_0000),
    parameter int                    ROM_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA    = DATA_WIDTH'(ERR_DATA_DEFAULT),
    localparam int                   IDX_W       = $clog2(DEPTH)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            req,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
    output logic [NUM_PORTS-1:0]            busy,
    output logic [NUM_PORTS-1:0]            rvalid,
    output logic [NUM_PORTS-1:0]            rerr,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] rdata,
    output logic [NUM_PORTS*IDX_W-1:0]      rom_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] rom_dout
);

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_ch
        rom_read_channel #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .DEPTH      (DEPTH),
            .IDX_W      (IDX_W),
            .BASE_ADDR  (BASE_ADDR),
            .ROM_LATENCY(ROM_LATENCY),
            .ERR_DATA   (ERR_DATA)
        ) u_ch (
            .clk_i     (clk),
            .rst_i     (rst),
            .req_i     (req[p]),
            .addr_i    (addr[p*ADDR_WIDTH +: ADDR_WIDTH]),
            .rom_dout_i(rom_dout[p*DATA_WIDTH +: DATA_WIDTH]),
            .busy_o    (busy[p]),
            .rvalid_o  (rvalid[p]),
            .rerr_o    (rerr[p]),
            .rdata_o   (rdata[p*DATA_WIDTH +: DATA_WIDTH]),
            .rom_addr_o(rom_addr[p*IDX_W +: IDX_W])
        );
    end

endmodule

// File: tb/tb_rom_multiport_reader.sv
// Directed bench for rom_multiport_reader: four instances at ROM_LATENCY 1..4
// share one stimulus stream; each has its own macro model.
module tb_rom_multiport_reader;

    localparam logic [31:0] BASE = 32'h1FC0_0000;
    localparam logic [31:0] ERRW = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [63:0] addr;

    logic [1:0]  busy_w   [1:4];
    logic [1:0]  rvalid_w [1:4];
    logic [1:0]  rerr_w   [1:4];
    logic [63:0] rdata_w  [1:4];
    logic [19:0] ra_w     [1:4];
    logic [63:0] dout_w   [1:4];

    int total = 0;
    int bad   = 0;

    int          seen   [1:4][0:1];
    int          at_c   [1:4][0:1];
    logic [31:0] dat    [1:4][0:1];
    logic        er     [1:4][0:1];
    logic [9:0]  prev_ra[1:4][0:1];

    function automatic logic [31:0] rom_word(input int i);
        if (i == 4) return 32'h1234_5678;
        return (32'(i) * 32'h0001_0003) ^ 32'h5A5A_0000;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 1; g <= 4; g++) begin : g_dut
        logic [19:0] dl [0:2];
        logic [19:0] ra_eff;

        rom_multiport_reader #(
            .NUM_PORTS  (2),
            .ROM_LATENCY(g)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .req     (req),
            .addr    (addr),
            .busy    (busy_w[g]),
            .rvalid  (rvalid_w[g]),
            .rerr    (rerr_w[g]),
            .rdata   (rdata_w[g]),
            .rom_addr(ra_w[g]),
            .rom_dout(dout_w[g])
        );

        // Macro model: read data settles ROM_LATENCY cycles after rom_addr.
        always @(posedge clk) begin
            dl[0] <= ra_w[g];
            dl[1] <= dl[0];
            dl[2] <= dl[1];
        end
        if (g == 1) begin : g_l1
            assign ra_eff = ra_w[g];
        end else begin : g_ln
            assign ra_eff = dl[g-2];
        end
        assign dout_w[g] = {rom_word(int'(ra_eff[19:10])),
                            rom_word(int'(ra_eff[9:0]))};
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic start(input logic [1:0] rq, input logic [31:0] a0,
                         input logic [31:0] a1);
        @(negedge clk);
        for (int g = 1; g <= 4; g++)
            for (int p = 0; p < 2; p++) begin
                seen[g][p]    = 0;
                at_c[g][p]    = 0;
                dat[g][p]     = '0;
                er[g][p]      = 1'b0;
                prev_ra[g][p] = ra_w[g][p*10 +: 10];
            end
        req  = rq;
        addr = {a1, a0};
    endtask

    // c counts negedges after the accepting edge; req drops at c == hold.
    task automatic watch(input int n, input int hold);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (c == hold) req = '0;
            for (int g = 1; g <= 4; g++)
                for (int p = 0; p < 2; p++)
                    if (rvalid_w[g][p]) begin
                        seen[g][p]++;
                        if (seen[g][p] == 1) begin
                            at_c[g][p] = c;
                            dat[g][p]  = rdata_w[g][p*32 +: 32];
                            er[g][p]   = rerr_w[g][p];
                        end
                    end
        end
    endtask

    task automatic expect_resp(input string tag, input int p, input bit good,
                               input int idx);
        for (int g = 1; g <= 4; g++) begin
            check($sformatf("%s L%0d cnt", tag, g), 64'(seen[g][p]), 64'd1);
            check($sformatf("%s L%0d at", tag, g), 64'(at_c[g][p]),
                  good ? 64'(g + 1) : 64'd1);
            check($sformatf("%s L%0d data", tag, g), 64'(dat[g][p]),
                  good ? 64'(rom_word(idx)) : 64'(ERRW));
            check($sformatf("%s L%0d rerr", tag, g), 64'(er[g][p]),
                  good ? 64'd0 : 64'd1);
            check($sformatf("%s L%0d raddr", tag, g),
                  64'(ra_w[g][p*10 +: 10]),
                  good ? 64'(idx) : 64'(prev_ra[g][p]));
        end
    endtask

    task automatic expect_zero(input string tag);
        for (int g = 1; g <= 4; g++) begin
            check($sformatf("%s L%0d busy", tag, g), 64'(busy_w[g]), 64'd0);
            check($sformatf("%s L%0d rvalid", tag, g), 64'(rvalid_w[g]), 64'd0);
            check($sformatf("%s L%0d rerr", tag, g), 64'(rerr_w[g]), 64'd0);
            check($sformatf("%s L%0d rdata", tag, g), rdata_w[g], 64'd0);
            check($sformatf("%s L%0d raddr", tag, g), 64'(ra_w[g]), 64'd0);
        end
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        addr = '0;
        repeat (2) @(negedge clk);
        expect_zero("reset");
        rst = 1'b0;

        start(2'b01, BASE + 32'h10, BASE);
        @(posedge clk);
        #1;
        for (int g = 1; g <= 4; g++)
            check($sformatf("busy0 L%0d", g), 64'(busy_w[g][0]), 64'd1);
        watch(8, 1);
        expect_resp("rd10", 0, 1'b1, 4);
        repeat (3) @(negedge clk);
        for (int g = 1; g <= 4; g++)
            check($sformatf("hold L%0d", g), rdata_w[g][31:0],
                  64'h1234_5678);

        start(2'b11, BASE + 32'h8, BASE + 32'hC);
        @(negedge clk);
        req = '0;
        rst = 1'b1;
        #1;
        expect_zero("rst_wait");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        start(2'b00, BASE, BASE);
        watch(8, 1);
        for (int g = 1; g <= 4; g++)
            for (int p = 0; p < 2; p++)
                check($sformatf("nodrop L%0d p%0d", g, p),
                      64'(seen[g][p]), 64'd0);

        start(2'b01, BASE + 32'h8, BASE);
        watch(8, 1);
        expect_resp("after_rst", 0, 1'b1, 2);

        start(2'b11, BASE, BASE + 32'h0FFC);
        watch(8, 1);
        expect_resp("both_p0", 0, 1'b1, 0);
        expect_resp("both_p1", 1, 1'b1, 1023);

        start(2'b10, BASE, BASE + 32'h1000);
        watch(8, 1);
        expect_resp("err_end", 1, 1'b0, 0);
        start(2'b10, BASE, BASE + 32'h2);
        watch(8, 1);
        expect_resp("err_align", 1, 1'b0, 0);
        start(2'b10, BASE, BASE - 32'h4);
        watch(8, 1);
        expect_resp("err_low", 1, 1'b0, 0);

        // Held request: accepts at edges 0, L+2, ... while edge < 10.
        start(2'b01, BASE + 32'h20, BASE);
        watch(20, 10);
        for (int g = 1; g <= 4; g++) begin
            check($sformatf("held L%0d", g), 64'(seen[g][0]),
                  64'((10 + g + 1) / (g + 2)));
            check($sformatf("held_idle L%0d", g), 64'(seen[g][1]), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
